// File: rtl/uart_rx_cfg_pkg.sv
// Shared types and helpers for the configurable UART receiver.
// Holds the parity mode, receiver state encoding and the baud divider calculation.
package uart_rx_cfg_pkg;

   typedef enum logic [1:0] {
      PAR_NONE,
      PAR_ODD,
      PAR_EVEN
   } parity_e;

   typedef enum logic [2:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_PARITY,
      RX_STOP,
      RX_DONE
   } rx_state_e;

   function automatic int clk_divide(input int freq, input int baud);
      return freq / baud;
   endfunction

endpackage

// File: rtl/uart_rx_cfg_if.sv
// Output side of the UART receiver: the received word, its valid/ready handshake and the error flags.
// The receiver drives through the master modport; the consumer uses the slave modport.
interface uart_rx_cfg_if #(
   parameter int DATA_BITS = 8
) ();

   logic [DATA_BITS-1:0] rx_data;
   logic                 rx_valid;
   logic                 rx_ready;
   logic                 parity_err;
   logic                 frame_err;
   logic                 overrun_err;

   modport master (
      output rx_data,
      output rx_valid,
      input  rx_ready,
      output parity_err,
      output frame_err,
      output overrun_err
   );

   modport slave (
      input  rx_data,
      input  rx_valid,
      output rx_ready,
      input  parity_err,
      input  frame_err,
      input  overrun_err
   );

endinterface

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for a single asynchronous input.
// Both flops reset to RESET_VAL so an idle-high line does not look like activity out of reset.
module uart_sync2 #(
   parameter logic RESET_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         meta_q <= RESET_VAL;
         q_o    <= RESET_VAL;
      end else begin
         meta_q <= d_i;
         q_o    <= meta_q;
      end
   end

endmodule

// File: rtl/uart_rx_cfg.sv
// Parametrised UART receiver: synchronised line input, glitch-rejecting start detect,
// configurable data/parity/stop format and a one-word holding register with error flags.
module uart_rx_cfg
   import uart_rx_cfg_pkg::*;
#(
   parameter int      CLK_FREQ  = 50_000_000,
   parameter int      BAUD_RATE = 19_200,
   parameter int      DATA_BITS = 8,
   parameter parity_e PARITY    = PAR_NONE,
   parameter int      STOP_BITS = 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          rx_i,
   output logic          busy_o,
   uart_rx_cfg_if.master rxIf
);

   localparam int CLK_DIVIDE = clk_divide(CLK_FREQ, BAUD_RATE);
   localparam int CNT_W      = $clog2(CLK_DIVIDE);
   localparam int IDX_W      = $clog2(DATA_BITS + 1);

   localparam logic [CNT_W-1:0] HALF_CNT  = CNT_W'((CLK_DIVIDE - 1) / 2);
   localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(CLK_DIVIDE - 1);
   localparam logic [IDX_W-1:0] LAST_BIT  = IDX_W'(DATA_BITS - 1);
   localparam logic [IDX_W-1:0] LAST_STOP = IDX_W'(STOP_BITS - 1);

   if (DATA_BITS < 5 || DATA_BITS > 9) begin : gBadDataBits
      $error("uart_rx_cfg: DATA_BITS must be 5..9");
   end
   if (STOP_BITS < 1 || STOP_BITS > 2) begin : gBadStopBits
      $error("uart_rx_cfg: STOP_BITS must be 1 or 2");
   end
   if (CLK_DIVIDE < 4) begin : gBadDivide
      $error("uart_rx_cfg: CLK_FREQ/BAUD_RATE must be at least 4");
   end

   logic rxS;

   uart_sync2 #(.RESET_VAL(1'b1)) uSync (
      .clk (clk),
      .rst (rst),
      .d_i (rx_i),
      .q_o (rxS)
   );

   rx_state_e            state_q,   state_d;
   logic [CNT_W-1:0]     clkDiv_q,  clkDiv_d;
   logic [IDX_W-1:0]     bitIdx_q,  bitIdx_d;
   logic [DATA_BITS-1:0] shift_q,   shift_d;
   logic                 armed_q,   armed_d;
   logic                 parErr_q,  parErr_d;
   logic                 frmErr_q,  frmErr_d;
   logic [DATA_BITS-1:0] data_q,    data_d;
   logic                 valid_q,   valid_d;
   logic                 heldPar_q, heldPar_d;
   logic                 heldFrm_q, heldFrm_d;
   logic                 overrun_q, overrun_d;

   // Frame sequencing and the holding-register handshake; the commit in RX_DONE overrides an accept.
   always_comb begin
      state_d   = state_q;
      clkDiv_d  = clkDiv_q;
      bitIdx_d  = bitIdx_q;
      shift_d   = shift_q;
      armed_d   = armed_q;
      parErr_d  = parErr_q;
      frmErr_d  = frmErr_q;
      data_d    = data_q;
      valid_d   = valid_q;
      heldPar_d = heldPar_q;
      heldFrm_d = heldFrm_q;
      overrun_d = overrun_q;

      unique case (state_q)
         RX_IDLE: begin
            clkDiv_d = '0;
            bitIdx_d = '0;
            if (!rxS && armed_q) begin
               state_d  = RX_START;
               armed_d  = 1'b0;
               parErr_d = 1'b0;
               frmErr_d = 1'b0;
            end else if (rxS) begin
               armed_d = 1'b1;
            end
         end
         RX_START: begin
            if (clkDiv_q == HALF_CNT) begin
               clkDiv_d = '0;
               state_d  = rxS ? RX_IDLE : RX_DATA;
            end else begin
               clkDiv_d = clkDiv_q + 1'b1;
            end
         end
         RX_DATA: begin
            if (clkDiv_q == LAST_CNT) begin
               clkDiv_d = '0;
               shift_d  = {rxS, shift_q[DATA_BITS-1:1]};
               if (bitIdx_q == LAST_BIT) begin
                  bitIdx_d = '0;
                  state_d  = (PARITY == PAR_NONE) ? RX_STOP : RX_PARITY;
               end else begin
                  bitIdx_d = bitIdx_q + 1'b1;
               end
            end else begin
               clkDiv_d = clkDiv_q + 1'b1;
            end
         end
         RX_PARITY: begin
            if (clkDiv_q == LAST_CNT) begin
               clkDiv_d = '0;
               parErr_d = ((^shift_q) ^ rxS) != (PARITY == PAR_ODD);
               state_d  = RX_STOP;
            end else begin
               clkDiv_d = clkDiv_q + 1'b1;
            end
         end
         RX_STOP: begin
            if (clkDiv_q == LAST_CNT) begin
               clkDiv_d = '0;
               if (!rxS) begin
                  frmErr_d = 1'b1;
               end
               if (bitIdx_q == LAST_STOP) begin
                  bitIdx_d = '0;
                  state_d  = RX_DONE;
               end else begin
                  bitIdx_d = bitIdx_q + 1'b1;
               end
            end else begin
               clkDiv_d = clkDiv_q + 1'b1;
            end
         end
         RX_DONE: begin
            state_d = RX_IDLE;
         end
         default: begin
            state_d = RX_IDLE;
         end
      endcase

      if (valid_q && rxIf.rx_ready) begin
         valid_d   = 1'b0;
         heldPar_d = 1'b0;
         heldFrm_d = 1'b0;
         overrun_d = 1'b0;
      end

      if (state_q == RX_DONE) begin
         if (!valid_q || rxIf.rx_ready) begin
            data_d    = shift_q;
            valid_d   = 1'b1;
            heldPar_d = parErr_q;
            heldFrm_d = frmErr_q;
         end else begin
            overrun_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= RX_IDLE;
         clkDiv_q  <= '0;
         bitIdx_q  <= '0;
         shift_q   <= '0;
         armed_q   <= 1'b0;
         parErr_q  <= 1'b0;
         frmErr_q  <= 1'b0;
         data_q    <= '0;
         valid_q   <= 1'b0;
         heldPar_q <= 1'b0;
         heldFrm_q <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         clkDiv_q  <= clkDiv_d;
         bitIdx_q  <= bitIdx_d;
         shift_q   <= shift_d;
         armed_q   <= armed_d;
         parErr_q  <= parErr_d;
         frmErr_q  <= frmErr_d;
         data_q    <= data_d;
         valid_q   <= valid_d;
         heldPar_q <= heldPar_d;
         heldFrm_q <= heldFrm_d;
         overrun_q <= overrun_d;
      end
   end

   assign rxIf.rx_data     = data_q;
   assign rxIf.rx_valid    = valid_q;
   assign rxIf.parity_err  = heldPar_q;
   assign rxIf.frame_err   = heldFrm_q;
   assign rxIf.overrun_err = overrun_q;
   assign busy_o           = (state_q != RX_IDLE);

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Self-checking bench for uart_rx_cfg: three configurations (8N1, 8E1, 9N2) driven with serial
// frames; expected words go into per-instance queues and are compared when the consumer accepts.
module tb_uart_rx_cfg;
   import uart_rx_cfg_pkg::*;

   localparam int BIT_CLKS = 16;

   typedef struct {
      int         dut;
      logic [8:0] data;
      bit         hasPar;
      logic       parBit;
      logic       expPerr;
      logic       expFerr;
   } vec_t;

   typedef struct {
      logic [8:0] data;
      logic       perr;
      logic       ferr;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic rxA = 1'b1;
   logic rxB = 1'b1;
   logic rxC = 1'b1;
   logic busyA, busyB, busyC;

   int checks   = 0;
   int failures = 0;
   int acceptA = 0, acceptB = 0, acceptC = 0;
   int validCycA = 0;

   exp_t expA[$];
   exp_t expB[$];
   exp_t expC[$];

   always #5 clk = ~clk;

   uart_rx_cfg_if #(.DATA_BITS(8)) ifA ();
   uart_rx_cfg_if #(.DATA_BITS(8)) ifB ();
   uart_rx_cfg_if #(.DATA_BITS(9)) ifC ();

   uart_rx_cfg #(
      .CLK_FREQ(1_600_000), .BAUD_RATE(100_000), .DATA_BITS(8), .PARITY(PAR_NONE), .STOP_BITS(1)
   ) dutA (
      .clk(clk), .rst(rst), .rx_i(rxA), .busy_o(busyA), .rxIf(ifA)
   );

   uart_rx_cfg #(
      .CLK_FREQ(1_600_000), .BAUD_RATE(100_000), .DATA_BITS(8), .PARITY(PAR_EVEN), .STOP_BITS(1)
   ) dutB (
      .clk(clk), .rst(rst), .rx_i(rxB), .busy_o(busyB), .rxIf(ifB)
   );

   uart_rx_cfg #(
      .CLK_FREQ(1_600_000), .BAUD_RATE(100_000), .DATA_BITS(9), .PARITY(PAR_NONE), .STOP_BITS(2)
   ) dutC (
      .clk(clk), .rst(rst), .rx_i(rxC), .busy_o(busyC), .rxIf(ifC)
   );

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   task automatic setLine(input int dut, input logic v);
      case (dut)
         0: rxA = v;
         1: rxB = v;
         default: rxC = v;
      endcase
   endtask

   task automatic holdBit(input int dut, input logic v);
      setLine(dut, v);
      repeat (BIT_CLKS) @(negedge clk);
   endtask

   task automatic idleBits(input int n);
      repeat (n * BIT_CLKS) @(negedge clk);
   endtask

   task automatic sendFrame(input int dut, input logic [8:0] data, input bit hasPar,
                            input logic parBit, input logic stopVal);
      int nBits;
      int nStops;
      nBits  = (dut == 2) ? 9 : 8;
      nStops = (dut == 2) ? 2 : 1;
      @(negedge clk);
      holdBit(dut, 1'b0);
      for (int i = 0; i < nBits; i++) holdBit(dut, data[i]);
      if (hasPar) holdBit(dut, parBit);
      for (int i = 0; i < nStops; i++) holdBit(dut, stopVal);
   endtask

   task automatic pushExp(input int dut, input logic [8:0] data, input logic perr, input logic ferr);
      exp_t e;
      e.data = data;
      e.perr = perr;
      e.ferr = ferr;
      case (dut)
         0: expA.push_back(e);
         1: expB.push_back(e);
         default: expC.push_back(e);
      endcase
   endtask

   task automatic applyStimulus(input vec_t v);
      pushExp(v.dut, v.data, v.expPerr, v.expFerr);
      sendFrame(v.dut, v.data, v.hasPar, v.parBit, 1'b1);
      setLine(v.dut, 1'b1);
      idleBits(2);
   endtask

   task automatic setReadyA(input logic v);
      @(posedge clk);
      #1;
      ifA.rx_ready = v;
   endtask

   // Scoreboard side: compare each accepted word against the oldest expectation for that instance.
   always @(negedge clk) begin
      exp_t e;
      if (!rst) begin
         if (ifA.rx_valid) validCycA++;
         if (ifA.rx_valid && ifA.rx_ready) begin
            acceptA++;
            if (expA.size() == 0) begin
               checks++; failures++;
               $display("[TB] FAIL A unexpected word: got 0x%0h, expected none", ifA.rx_data);
            end else begin
               e = expA.pop_front();
               checkOutput("A rx_data", 32'(ifA.rx_data), 32'(e.data));
               checkOutput("A parity_err", 32'(ifA.parity_err), 32'(e.perr));
               checkOutput("A frame_err", 32'(ifA.frame_err), 32'(e.ferr));
            end
         end
         if (ifB.rx_valid && ifB.rx_ready) begin
            acceptB++;
            if (expB.size() == 0) begin
               checks++; failures++;
               $display("[TB] FAIL B unexpected word: got 0x%0h, expected none", ifB.rx_data);
            end else begin
               e = expB.pop_front();
               checkOutput("B rx_data", 32'(ifB.rx_data), 32'(e.data));
               checkOutput("B parity_err", 32'(ifB.parity_err), 32'(e.perr));
               checkOutput("B frame_err", 32'(ifB.frame_err), 32'(e.ferr));
            end
         end
         if (ifC.rx_valid && ifC.rx_ready) begin
            acceptC++;
            if (expC.size() == 0) begin
               checks++; failures++;
               $display("[TB] FAIL C unexpected word: got 0x%0h, expected none", ifC.rx_data);
            end else begin
               e = expC.pop_front();
               checkOutput("C rx_data", 32'(ifC.rx_data), 32'(e.data));
               checkOutput("C parity_err", 32'(ifC.parity_err), 32'(e.perr));
               checkOutput("C frame_err", 32'(ifC.frame_err), 32'(e.ferr));
            end
         end
      end
   end

   initial begin
      #3_000_000;
      $display("[TB] FAIL watchdog: simulation exceeded its time budget");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      vec_t vectors[12];
      int   base;
      bit   sawBusy;

      vectors[0]  = '{0, 9'h0A5, 1'b0, 1'b0, 1'b0, 1'b0};
      vectors[1]  = '{0, 9'h000, 1'b0, 1'b0, 1'b0, 1'b0};
      vectors[2]  = '{0, 9'h0FF, 1'b0, 1'b0, 1'b0, 1'b0};
      vectors[3]  = '{0, 9'h03C, 1'b0, 1'b0, 1'b0, 1'b0};
      vectors[4]  = '{1, 9'h007, 1'b1, 1'b0, 1'b1, 1'b0};
      vectors[5]  = '{1, 9'h007, 1'b1, 1'b1, 1'b0, 1'b0};
      vectors[6]  = '{1, 9'h000, 1'b1, 1'b0, 1'b0, 1'b0};
      vectors[7]  = '{1, 9'h0FF, 1'b1, 1'b1, 1'b1, 1'b0};
      vectors[8]  = '{1, 9'h080, 1'b1, 1'b1, 1'b0, 1'b0};
      vectors[9]  = '{2, 9'h1FF, 1'b0, 1'b0, 1'b0, 1'b0};
      vectors[10] = '{2, 9'h001, 1'b0, 1'b0, 1'b0, 1'b0};
      vectors[11] = '{2, 9'h0AA, 1'b0, 1'b0, 1'b0, 1'b0};

      ifA.rx_ready = 1'b1;
      ifB.rx_ready = 1'b1;
      ifC.rx_ready = 1'b1;
      rst = 1'b1;
      repeat (5) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      $display("[TB] reset state");
      checkOutput("reset A rx_valid", 32'(ifA.rx_valid), 32'd0);
      checkOutput("reset A rx_data", 32'(ifA.rx_data), 32'd0);
      checkOutput("reset A parity_err", 32'(ifA.parity_err), 32'd0);
      checkOutput("reset A frame_err", 32'(ifA.frame_err), 32'd0);
      checkOutput("reset A overrun_err", 32'(ifA.overrun_err), 32'd0);
      checkOutput("reset A busy", 32'(busyA), 32'd0);
      checkOutput("reset C rx_valid", 32'(ifC.rx_valid), 32'd0);
      idleBits(1);

      $display("[TB] 8N1 0xA5 single-cycle valid");
      base = validCycA;
      pushExp(0, 9'h0A5, 1'b0, 1'b0);
      sendFrame(0, 9'h0A5, 1'b0, 1'b0, 1'b1);
      idleBits(2);
      checkOutput("A5 valid cycles", 32'(validCycA - base), 32'd1);
      checkOutput("A5 busy after", 32'(busyA), 32'd0);

      $display("[TB] vector table");
      for (int i = 0; i < 12; i++) applyStimulus(vectors[i]);
      checkOutput("A accepted count", 32'(acceptA), 32'd5);
      checkOutput("B accepted count", 32'(acceptB), 32'd5);
      checkOutput("C accepted count", 32'(acceptC), 32'd3);

      $display("[TB] hold and overrun");
      setReadyA(1'b0);
      pushExp(0, 9'h011, 1'b0, 1'b0);
      sendFrame(0, 9'h011, 1'b0, 1'b0, 1'b1);
      idleBits(3);
      checkOutput("held rx_valid", 32'(ifA.rx_valid), 32'd1);
      checkOutput("held rx_data", 32'(ifA.rx_data), 32'h11);
      checkOutput("held overrun_err", 32'(ifA.overrun_err), 32'd0);
      sendFrame(0, 9'h022, 1'b0, 1'b0, 1'b1);
      idleBits(2);
      checkOutput("overrun rx_data", 32'(ifA.rx_data), 32'h11);
      checkOutput("overrun flag", 32'(ifA.overrun_err), 32'd1);
      checkOutput("overrun rx_valid", 32'(ifA.rx_valid), 32'd1);
      setReadyA(1'b1);
      @(negedge clk);
      @(negedge clk);
      checkOutput("after accept rx_valid", 32'(ifA.rx_valid), 32'd0);
      checkOutput("after accept overrun", 32'(ifA.overrun_err), 32'd0);
      idleBits(1);

      $display("[TB] break condition");
      base = acceptA;
      pushExp(0, 9'h055, 1'b0, 1'b1);
      sendFrame(0, 9'h055, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) holdBit(0, 1'b0);
      checkOutput("break words while low", 32'(acceptA - base), 32'd1);
      checkOutput("break busy while low", 32'(busyA), 32'd0);
      setLine(0, 1'b1);
      idleBits(2);
      checkOutput("break words after high", 32'(acceptA - base), 32'd1);

      $display("[TB] start glitch");
      base = acceptA;
      sawBusy = 1'b0;
      @(negedge clk);
      rxA = 1'b0;
      repeat (4) begin
         @(negedge clk);
         if (busyA) sawBusy = 1'b1;
      end
      rxA = 1'b1;
      repeat (10) begin
         @(negedge clk);
         if (busyA) sawBusy = 1'b1;
      end
      checkOutput("glitch busy seen", 32'(sawBusy), 32'd1);
      checkOutput("glitch busy cleared", 32'(busyA), 32'd0);
      idleBits(2);
      checkOutput("glitch no word", 32'(acceptA - base), 32'd0);

      $display("[TB] reset mid-frame, 9N2");
      base = acceptC;
      @(negedge clk);
      holdBit(2, 1'b0);
      holdBit(2, 1'b0);
      holdBit(2, 1'b0);
      holdBit(2, 1'b1);
      rxC = 1'b1;
      repeat (8) @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      idleBits(3);
      checkOutput("midreset busy", 32'(busyC), 32'd0);
      checkOutput("midreset rx_valid", 32'(ifC.rx_valid), 32'd0);
      checkOutput("midreset no word", 32'(acceptC - base), 32'd0);
      pushExp(2, 9'h13C, 1'b0, 1'b0);
      sendFrame(2, 9'h13C, 1'b0, 1'b0, 1'b1);
      setLine(2, 1'b1);
      idleBits(3);
      checkOutput("midreset word received", 32'(acceptC - base), 32'd1);

      checkOutput("A queue drained", 32'(expA.size()), 32'd0);
      checkOutput("B queue drained", 32'(expB.size()), 32'd0);
      checkOutput("C queue drained", 32'(expC.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
